// File: rtl/onchip_mem_master_if.sv
// Avalon-MM style memory port used by onchip_mem_master.
//
// Signals:
//   m_address    word address of the current transfer
//   m_byteenable byte enables (all ones on writes)
//   m_chipselect qualifies a transfer in the current cycle
//   m_write      1 = write, 0 = read (meaningful only with m_chipselect)
//   m_writedata  write data
//   m_clken      memory clock enable
//   m_readdata   read data, valid exactly one cycle after a read is issued
//
// Modports: master (the tester drives the bus), slave (the memory).
interface onchip_mem_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/onchip_mem_master.sv
// On-chip memory tester: writes an incrementing pattern (seed+i) to a block
// of words starting at base_addr, reads the block back and counts mismatches.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start            run request, sampled only in IDLE
//   base_addr        first word address (captured on accepted start)
//   length           word count 0..2^ADDR_W (captured on accepted start)
//   seed             pattern seed (captured on accepted start)
//   busy             high during WRITE, READ and DRAIN
//   done             one-cycle end-of-run pulse
//   pass             last run had zero mismatches (held until next start)
//   err_count        mismatch count of the last run
//   first_err_addr   address of the first mismatch of the last run
//   state_dbg        current FSM state
//   m                memory bus (master side)
//
// Control handshake: there is no ready/valid pair. start is a level that is
// only looked at while IDLE; the run it triggers always completes (unless
// reset) and signals completion with a single-cycle done pulse. The memory
// bus has no waitrequest, so every issued transfer completes in its cycle.
module onchip_mem_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [2:0]          state_dbg,
    onchip_mem_master_if.master m
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, addr_q, exp_addr_q;
    logic [DATA_W-1:0] seed_q, data_q, exp_data_q;
    logic [ADDR_W:0]   len_q, cnt_q;
    logic              cmp_valid_q;
    logic [ADDR_W:0]   err_count_q;
    logic [ADDR_W-1:0] first_err_q;
    logic              pass_q;

    logic              last_beat;
    logic              mismatch;
    logic [ADDR_W:0]   err_count_nxt;

    assign last_beat     = (cnt_q == (ADDR_W+1)'(1));
    // A read issued last cycle returns now; compare with its pipelined expectation.
    assign mismatch      = cmp_valid_q && (m.m_readdata != exp_data_q);
    assign err_count_nxt = err_count_q + {{ADDR_W{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (last_beat) state_d = S_READ;
            S_READ:  if (last_beat) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            seed_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            exp_addr_q  <= '0;
            exp_data_q  <= '0;
            cmp_valid_q <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            cmp_valid_q <= (state_q == S_READ);
            exp_addr_q  <= addr_q;
            exp_data_q  <= data_q;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        seed_q      <= seed;
                        len_q       <= length;
                        addr_q      <= base_addr;
                        data_q      <= seed;
                        cnt_q       <= length;
                        err_count_q <= '0;
                        first_err_q <= '0;
                        // An empty run has nothing to miscompare.
                        pass_q      <= (length == '0);
                    end
                end
                S_WRITE: begin
                    if (last_beat) begin
                        // Rewind to replay the same address/data sequence for reads.
                        addr_q <= base_q;
                        data_q <= seed_q;
                        cnt_q  <= len_q;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        data_q <= data_q + DATA_W'(1);
                        cnt_q  <= cnt_q - (ADDR_W+1)'(1);
                    end
                end
                S_READ: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    data_q <= data_q + DATA_W'(1);
                    cnt_q  <= cnt_q - (ADDR_W+1)'(1);
                end
                S_DRAIN: begin
                    // Last comparison lands this cycle, so use the updated count.
                    pass_q <= (err_count_nxt == '0);
                end
                default: ;
            endcase

            if (mismatch) begin
                err_count_q <= err_count_nxt;
                if (err_count_q == '0) first_err_q <= exp_addr_q;
            end
        end
    end

    assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign state_dbg      = state_q;

    assign m.m_address    = addr_q;
    assign m.m_writedata  = data_q;
    assign m.m_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
    assign m.m_write      = (state_q == S_WRITE);
    assign m.m_byteenable = (state_q == S_WRITE) ? '1 : '0;
    assign m.m_clken      = reset_n;

endmodule

// File: doc/onchip_mem_master.md
ONCHIP_MEM_MASTER -- requirements
Module: onchip_mem_master

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the word address width of the memory port.
REQ-002 Parameter DATA_W, default 64, SHALL set the data width; byteenable width SHALL be DATA_W/8.
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL be rising-edge clocked on clk.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the run request, sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  SHALL be the first word address, captured on accepted start.
REQ-007 length  input  ADDR_W+1  SHALL be the word count (0..2^ADDR_W), captured on accepted start.
REQ-008 seed  input  DATA_W  SHALL be the pattern seed, captured on accepted start.
REQ-009 busy  output  1  SHALL be high while a run is in progress.
REQ-010 done  output  1  SHALL be a one-cycle end-of-run pulse.
REQ-011 pass  output  1  SHALL be high when the last run had zero mismatches.
REQ-012 err_count  output  ADDR_W+1  SHALL be the mismatch count of the last run.
REQ-013 first_err_addr  output  ADDR_W  SHALL be the address of the first mismatch of the last run.
REQ-014 m_address  output  ADDR_W  SHALL be the Avalon-MM word address.
REQ-015 m_byteenable  output  DATA_W/8  SHALL be the byte enables.
REQ-016 m_chipselect  output  1  SHALL qualify a transfer.
REQ-017 m_write  output  1  SHALL select write (1) or read (0) when m_chipselect=1.
REQ-018 m_writedata  output  DATA_W  SHALL be the write data.
REQ-019 m_clken  output  1  SHALL be the memory clock enable.
REQ-020 m_readdata  input  DATA_W  SHALL be the read data, valid exactly one cycle after a read is issued (no waitrequest).

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 IDLE->WRITE on start=1 with length!=0; IDLE->DONE on start=1 with length=0 (no bus transfers, err_count=0); start SHALL be ignored outside IDLE.
REQ-023 Word i (0..length-1) SHALL use address (base_addr+i) mod 2^ADDR_W and data (seed+i) mod 2^DATA_W.
REQ-024 WRITE SHALL issue one write per cycle: m_chipselect=1, m_write=1, m_byteenable all ones, for exactly length cycles, then go to READ.
REQ-025 READ SHALL issue one read per cycle (m_chipselect=1, m_write=0) over the same address sequence for exactly length cycles, then go to DRAIN.
REQ-026 Each m_readdata word SHALL be compared with its expected data in the cycle after its read; expected data and address SHALL be pipelined one stage to align.
REQ-027 On mismatch err_count SHALL increment by one; the first mismatch of a run SHALL load first_err_addr; later mismatches SHALL not change it.
REQ-028 DRAIN SHALL last one cycle (last comparison), then go to DONE; DONE SHALL last one cycle, assert done, then go to IDLE.
REQ-029 Timing with start accepted at cycle 0 and length L>0: writes cycles 1..L, reads L+1..2L, DRAIN 2L+1, done at 2L+2; busy high cycles 1..2L+1.
REQ-030 On accepted start err_count, first_err_addr SHALL clear to 0 and pass SHALL clear to 0; pass SHALL be set to (err_count==0) when done asserts and hold until next accepted start.
REQ-031 Address wrap past 2^ADDR_W-1 SHALL continue at 0 with no error flag.
REQ-032 m_clken SHALL be 1 whenever reset_n=1; m_chipselect SHALL be 0 in IDLE, DRAIN, DONE.

Reset
REQ-033 reset_n=0 SHALL immediately force FSM to IDLE and busy, done, pass, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata, m_clken to 0, m_byteenable to 0.
REQ-034 Reset during a run SHALL abort it with no done pulse; memory contents are then undefined; a new start after reset release SHALL run normally.

Verification
REQ-035 base_addr=0x0010, length=4, seed=0x100, ideal memory -> writes 0x100..0x103 to 0x10..0x13, reads same, done at cycle 10, pass=1, err_count=0.
REQ-036 base_addr=0x1FFE, length=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001 in both phases, pass=1.
REQ-037 Memory model corrupts read of address 0x0005 and 0x0007 (base 0, length 8) -> err_count=2, first_err_addr=0x0005, pass=0.
REQ-038 length=0 with start -> no m_chipselect, done at cycle 1, pass=1, err_count=0.
REQ-039 reset_n pulsed low at cycle 3 of a length=8 run -> all outputs 0 asynchronously, no done; subsequent run of length=2 passes.
REQ-040 start held high throughout a length=3 run -> second run begins only from IDLE after done, back-to-back runs each pass.
